// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO for the EX stage.
// Iterative work shares one 2*DATA_W accumulator: {partial, multiplier} for MUL, {remainder, quotient} for DIV.
module hilo_muldiv #(
    parameter int DATA_W   = 32,
    parameter int MUL_ITER = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              stallreq,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);
    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110
    } op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_e;

    state_e              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   opnd;
    logic [2*DATA_W-1:0] acc;
    logic                neg_res;
    logic                neg_rem;

    logic                is_mul;
    logic                is_div;
    logic                is_signed;
    logic                issue;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] mul_next;
    logic [DATA_W:0]     div_trial;
    logic [2*DATA_W-1:0] div_next;
    logic [2*DATA_W-1:0] step_next;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix;
    logic [DATA_W-1:0]   rem_fix;
    logic [DATA_W-1:0]   res_hi;
    logic [DATA_W-1:0]   res_lo;

    // NOTE: every signal assigned in always_comb is given a value on every path, so no latch is inferred.
    always_comb begin
        is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        is_div    = (op == OP_DIV) || (op == OP_DIVU);
        is_signed = (op == OP_MULT) || (op == OP_DIV);
        mag_a     = (is_signed && src_a[DATA_W-1]) ? -src_a : src_a;
        mag_b     = (is_signed && src_b[DATA_W-1]) ? -src_b : src_b;
        issue     = (state == ST_IDLE) && op_valid && (is_mul || is_div) && !cancel;

        // Shift-add step: add multiplicand into the upper half when the multiplier LSB is set, then shift right.
        mul_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
        if (MUL_ITER == 0) begin
            mul_next = {{DATA_W{1'b0}}, opnd} * {{DATA_W{1'b0}}, acc[DATA_W-1:0]};
        end else begin
            mul_next = {mul_sum, acc[DATA_W-1:1]};
        end

        // Restoring step: a borrow out of the trial subtract means keep the shifted remainder.
        div_trial = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]} - {1'b0, opnd};
        div_next  = div_trial[DATA_W] ? {acc[2*DATA_W-2:0], 1'b0}
                                      : {div_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};

        step_next = (state == ST_DIV) ? div_next : mul_next;
        prod_fix  = neg_res ? -mul_next : mul_next;
        quo_fix   = neg_res ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
        rem_fix   = neg_rem ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
        res_hi    = (state == ST_DIV) ? rem_fix : prod_fix[2*DATA_W-1:DATA_W];
        res_lo    = (state == ST_DIV) ? quo_fix : prod_fix[DATA_W-1:0];
    end

    assign busy     = (state == ST_MUL) || (state == ST_DIV);
    assign stallreq = issue || (busy && !cancel);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            opnd    <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        neg_res <= is_signed && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
                        neg_rem <= is_signed && src_a[DATA_W-1];
                        if (is_mul) begin
                            opnd  <= mag_a;
                            acc   <= {{DATA_W{1'b0}}, mag_b};
                            cnt   <= (MUL_ITER == 0) ? CNT_W'(1) : CNT_W'(DATA_W);
                            state <= ST_MUL;
                        end else begin
                            opnd  <= mag_b;
                            acc   <= {{DATA_W{1'b0}}, mag_a};
                            cnt   <= CNT_W'(DATA_W);
                            state <= ST_DIV;
                        end
                    end else if (op_valid && !cancel) begin
                        if (op == OP_MTHI) begin
                            hi <= src_a;
                        end else if (op == OP_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cancel) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            hi    <= res_hi;
                            lo    <= res_lo;
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: one instance per multiply style, directed plan cases plus random ops
// checked against an arithmetic reference model of HI/LO and stall length.
module tb_hilo_muldiv;
    localparam int W = 32;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    logic         clk = 1'b0;
    logic [1:0]   rst;
    logic [1:0]   op_valid;
    logic [1:0]   cancel;
    logic [1:0]   stallreq_w;
    logic [1:0]   busy_w;
    logic [2:0]   op    [2];
    logic [W-1:0] src_a [2];
    logic [W-1:0] src_b [2];
    logic [W-1:0] hi_w  [2];
    logic [W-1:0] lo_w  [2];
    logic [W-1:0] m_hi  [2];
    logic [W-1:0] m_lo  [2];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    hilo_muldiv #(.DATA_W(W), .MUL_ITER(0)) dut0 (
        .clk(clk), .rst(rst[0]), .op_valid(op_valid[0]), .op(op[0]),
        .src_a(src_a[0]), .src_b(src_b[0]), .cancel(cancel[0]),
        .stallreq(stallreq_w[0]), .busy(busy_w[0]), .hi(hi_w[0]), .lo(lo_w[0])
    );

    hilo_muldiv #(.DATA_W(W), .MUL_ITER(1)) dut1 (
        .clk(clk), .rst(rst[1]), .op_valid(op_valid[1]), .op(op[1]),
        .src_a(src_a[1]), .src_b(src_b[1]), .cancel(cancel[1]),
        .stallreq(stallreq_w[1]), .busy(busy_w[1]), .hi(hi_w[1]), .lo(lo_w[1])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: signed/unsigned products by plain multiplication; division by magnitudes with the
    // divide-by-zero convention (quotient all ones, remainder = dividend magnitude), then sign fix.
    function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] eh, output logic [W-1:0] el);
        logic [2*W-1:0] p;
        logic [W-1:0]   ma, mb, q, r;
        logic           sa, sb;
        sa = (o == OP_DIV) && a[W-1];
        sb = (o == OP_DIV) && b[W-1];
        case (o)
            OP_MULT:  p = longint'($signed(a)) * longint'($signed(b));
            OP_MULTU: p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            default: begin
                ma = sa ? -a : a;
                mb = sb ? -b : b;
                q  = (mb == '0) ? '1 : ma / mb;
                r  = (mb == '0) ? ma : ma % mb;
                if (sa ^ sb) q = -q;
                if (sa) r = -r;
                p = {r, q};
            end
        endcase
        eh = p[2*W-1:W];
        el = p[W-1:0];
    endfunction

    function automatic int exp_stall(input int d, input logic [2:0] o);
        return (d == 0 && (o == OP_MULT || o == OP_MULTU)) ? 2 : W + 1;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return 32'd1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one MUL/DIV op, scramble operands while stalled, and check results in the DONE cycle.
    task automatic run_md(input int d, input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input int stall_len, input bit keep);
        int n;
        @(negedge clk);
        op_valid[d] = 1'b1;
        op[d]       = o;
        src_a[d]    = a;
        src_b[d]    = b;
        cancel[d]   = 1'b0;
        #1;
        check("issue_stall", stallreq_w[d], 1'b1);
        n = 0;
        while (stallreq_w[d] && n < 64) begin
            n++;
            @(negedge clk);
            src_a[d] = $urandom;
            src_b[d] = $urandom;
            #1;
        end
        check("stall_len", n, stall_len);
        check("done_busy", busy_w[d], 1'b0);
        check("res_hi", hi_w[d], eh);
        check("res_lo", lo_w[d], el);
        m_hi[d] = eh;
        m_lo[d] = el;
        if (!keep) op_valid[d] = 1'b0;
    endtask

    // MTHI/MTLO or a no-op code for one cycle, optionally flushed; HI/LO checked the next cycle.
    task automatic run_mt(input int d, input logic [2:0] o, input logic [W-1:0] a, input bit flush);
        @(negedge clk);
        op_valid[d] = 1'b1;
        op[d]       = o;
        src_a[d]    = a;
        src_b[d]    = $urandom;
        cancel[d]   = flush;
        #1;
        check("mt_stall", stallreq_w[d], 1'b0);
        if (!flush && o == OP_MTHI) m_hi[d] = a;
        if (!flush && o == OP_MTLO) m_lo[d] = a;
        @(negedge clk);
        op_valid[d] = 1'b0;
        cancel[d]   = 1'b0;
        #1;
        check("mt_hi", hi_w[d], m_hi[d]);
        check("mt_lo", lo_w[d], m_lo[d]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   o;
        logic [W-1:0] a, b, eh, el;
        int           d;

        rst      = 2'b11;
        op_valid = 2'b00;
        cancel   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            op[k]    = '0;
            src_a[k] = '0;
            src_b[k] = '0;
            m_hi[k]  = '0;
            m_lo[k]  = '0;
        end
        repeat (2) @(negedge clk);
        rst = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) begin
            check("rst_hi", hi_w[k], '0);
            check("rst_lo", lo_w[k], '0);
            check("rst_stall", stallreq_w[k], 1'b0);
            check("rst_busy", busy_w[k], 1'b0);
        end

        // Multiplies on both styles.
        for (int k = 0; k < 2; k++) begin
            run_md(k, OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, (k == 0) ? 2 : 33, 1'b0);
            run_md(k, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
                   (k == 0) ? 2 : 33, 1'b0);
        end

        // Divides, including divide by zero and the overflow case.
        run_md(1, OP_DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33, 1'b0);
        run_md(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
        run_md(1, OP_DIV, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 33, 1'b0);
        run_md(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, 1'b0);

        // MT writes on consecutive cycles, then a flushed MT that must not write.
        @(negedge clk);
        op_valid[1] = 1'b1;
        op[1]       = OP_MTHI;
        src_a[1]    = 32'h1234_5678;
        #1;
        check("mthi_stall", stallreq_w[1], 1'b0);
        @(negedge clk);
        op[1]    = OP_MTLO;
        src_a[1] = 32'h9ABC_DEF0;
        #1;
        check("mtlo_stall", stallreq_w[1], 1'b0);
        check("mthi_val", hi_w[1], 32'h1234_5678);
        @(negedge clk);
        op_valid[1] = 1'b0;
        #1;
        check("mtlo_val", lo_w[1], 32'h9ABC_DEF0);
        m_hi[1] = 32'h1234_5678;
        m_lo[1] = 32'h9ABC_DEF0;
        run_mt(1, OP_MTHI, 32'hDEAD_BEEF, 1'b1);

        // DIV flushed at T+10.
        @(negedge clk);
        op_valid[1] = 1'b1;
        op[1]       = OP_DIV;
        src_a[1]    = 32'h0000_1000;
        src_b[1]    = 32'd3;
        #1;
        check("cxl_issue", stallreq_w[1], 1'b1);
        repeat (10) @(negedge clk);
        cancel[1] = 1'b1;
        #1;
        check("cxl_stall", stallreq_w[1], 1'b0);
        check("cxl_busy_t10", busy_w[1], 1'b1);
        @(negedge clk);
        op_valid[1] = 1'b0;
        cancel[1]   = 1'b0;
        #1;
        check("cxl_busy_t11", busy_w[1], 1'b0);
        check("cxl_stall_t11", stallreq_w[1], 1'b0);
        repeat (40) @(negedge clk);
        #1;
        check("cxl_hi", hi_w[1], m_hi[1]);
        check("cxl_lo", lo_w[1], m_lo[1]);

        // Back-to-back DIVU then MULTU with op_valid held through DONE.
        run_md(1, OP_DIVU, 32'd1000, 32'd9, 32'h0000_0001, 32'h0000_006F, 33, 1'b1);
        run_md(1, OP_MULTU, 32'h0001_0000, 32'h0001_0001, 32'h0000_0001, 32'h0001_0000, 33, 1'b0);
        @(negedge clk);
        #1;
        check("b2b_end_stall", stallreq_w[1], 1'b0);
        check("b2b_end_busy", busy_w[1], 1'b0);

        // Reset in the middle of a divide.
        @(negedge clk);
        op_valid[1] = 1'b1;
        op[1]       = OP_DIV;
        src_a[1]    = 32'd12345;
        src_b[1]    = 32'd11;
        repeat (5) @(negedge clk);
        rst[1]      = 1'b1;
        op_valid[1] = 1'b0;
        @(negedge clk);
        rst[1] = 1'b0;
        #1;
        check("mrst_hi", hi_w[1], '0);
        check("mrst_lo", lo_w[1], '0);
        check("mrst_busy", busy_w[1], 1'b0);
        check("mrst_stall", stallreq_w[1], 1'b0);
        m_hi[1] = '0;
        m_lo[1] = '0;

        // Random mix of every op code on both instances.
        for (int i = 0; i < 60; i++) begin
            d = i % 2;
            o = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            if (o == OP_MULT || o == OP_MULTU || o == OP_DIV || o == OP_DIVU) begin
                model(o, a, b, eh, el);
                run_md(d, o, a, b, eh, el, exp_stall(d, o), 1'b0);
            end else begin
                run_mt(d, o, a, ($urandom_range(0, 3) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised multiply/divide unit with architectural HI/LO registers for the EX stage of the five-stage core. It executes MULT/MULTU/DIV/DIVU over several cycles and holds the pipeline through `stallreq` into CTRL. It also performs MTHI/MTLO writes and can be annulled mid-operation by a pipeline flush. Operand width, multiply style and divider iteration are set by parameters.

## Interface
- `DATA_W`, 32: operand and HI/LO width; even, ≥ 8.
- `MUL_ITER`, 0: 0 = registered single-cycle multiply; 1 = iterative shift-add multiply, `DATA_W` cycles.
- `clk`  in  1  clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `op_valid`  in  1  EX holds a HI/LO instruction this cycle.
- `op`  in  3  operation: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; all other codes are no-op.
- `src_a`  in  `DATA_W`  rs value (dividend / multiplicand / MT source).
- `src_b`  in  `DATA_W`  rt value (divisor / multiplier).
- `cancel`  in  1  flush: abort any in-flight or issuing op.
- `stallreq`  out  1  to CTRL; hold IF..EX while high.
- `busy`  out  1  state is MUL or DIV.
- `hi`, `lo`  out  `DATA_W`  architectural registers (MFHI/MFLO source).

## Operation
- **States:** IDLE, MUL, DIV, DONE. Iteration counter width is clog2(`DATA_W`)+1.
- **Issue:** in IDLE with `op_valid` & MUL/DIV op & !`cancel`, the unit latches:
  - |`src_a`| and |`src_b`|, where magnitude is taken only for signed ops;
  - the quotient/product sign (signs differ) and the remainder sign (dividend sign).
  - Then it goes to MUL or DIV and loads the counter: `DATA_W`, or 1 for MUL with `MUL_ITER`=0.
- **Operand changes:** `src_a`/`src_b` changes after issue are ignored.
- **MUL:**
  - `MUL_ITER`=0: one cycle; the latched-magnitude product is formed and written.
  - `MUL_ITER`=1: each cycle adds the shifted multiplicand when the current multiplier bit is 1; 2·`DATA_W`-bit accumulator.
  - At completion, sign fix (two's-complement negate of the 2·`DATA_W` product if the sign flag is set) gives {`hi`,`lo`} and the state goes to DONE.
- **DIV:** restoring radix-2, one quotient bit per cycle.
  - At completion: `lo` = quotient (negated if the quotient sign is set), `hi` = remainder (negated if the dividend was negative). Then DONE.
  - Divide by zero follows the algorithm: magnitude quotient all-ones, magnitude remainder |a|, then sign fix. No exception; latency is normal.
  - DIV 0x80000000/-1 (DATA_W=32) gives `lo`=0x80000000, `hi`=0.
- **DONE:** one cycle. `op_valid` is ignored, because the held completed instruction is leaving EX. Next state is IDLE.
- **MTHI/MTLO:** in IDLE with `op_valid` & !`cancel`, `src_a` is written to `hi`/`lo` at the clock edge. No stall. Outside IDLE the write is ignored; this cannot occur while stalled.
- **`cancel`:**
  - In MUL/DIV: next state IDLE, `hi`/`lo` unchanged, partial results discarded.
  - In IDLE: suppresses issue and MT writes.
  - In DONE: no effect, since `hi`/`lo` were already written.
- **`stallreq`** = (IDLE & `op_valid` & MUL/DIV op & !`cancel`) | ((MUL|DIV) & !`cancel`).

## Timing
- **Reset:** `hi`=0, `lo`=0, state IDLE, `stallreq`=0, `busy`=0, counter 0, internal registers 0. `rst` mid-operation aborts the op and zeroes HI/LO.
- **Issue cycle T:** `stallreq`=1 combinationally.
- **DIV, and MUL with `MUL_ITER`=1:**
  - Busy cycles are T+1..T+`DATA_W`.
  - `hi`/`lo` update at the edge ending T+`DATA_W`.
  - DONE is T+`DATA_W`+1, with `stallreq`=0.
  - `stallreq` is high for `DATA_W`+1 cycles.
- **MUL with `MUL_ITER`=0:** busy at T+1, write at the end of T+1, DONE at T+2; `stallreq` is high for 2 cycles.
- **Back-to-back:** the earliest next issue is the cycle after DONE.
- **MFHI/MFLO visibility:** a following MFHI/MFLO reads updated `hi`/`lo` because its EX cycle is ≥ DONE+1.
- **MT writes:** visible on `hi`/`lo` the cycle after the write.

## Test plan
- MULT `src_a`=0xFFFFFFFD (-3), `src_b`=5, both `MUL_ITER` values → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. `stallreq` is high 2 / 33 cycles respectively.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. Operands changed after T must not affect the result.
- DIVU 100/7 → `lo`=0x0000000E, `hi`=0x00000002. DIV -7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV 7/0 → `lo`=0xFFFFFFFF, `hi`=0x00000007. Each takes 33 stall cycles.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → no stall; `hi`/`lo` hold the values. Then DIV with `cancel` at T+10 → state IDLE at T+11, `hi`/`lo` unchanged, `stallreq`=0 from T+10.
- Back-to-back DIVU then MULTU, with `op_valid` held through DONE → exactly two operations are performed; the second issues at DONE+1. `rst` asserted mid-DIV → `hi`=`lo`=0 and IDLE the next cycle.
